// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, per-scan key bitmap,
// priority encode and press/release debounce producing the key/key_pulse bus.
module keypad_scan #(
    parameter int SCAN_DIV     = 25000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [4:0] key,
    output logic [4:0] key_pulse
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_e;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       key_col_q, key_col_d;
    logic [15:0]      bitmap_q, bitmap_d;
    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [4:0]       key_q, key_d;
    logic [4:0]       key_pulse_q, key_pulse_d;

    logic        tick, scan_done, raw_valid;
    logic [15:0] bitmap_now;
    logic [3:0]  raw_code, cnt_inc;

    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    always_comb begin
        tick      = (div_q == DIV_LAST);
        scan_done = tick && (col_idx_q == 2'd3);

        bitmap_now = bitmap_q;
        if (tick) begin
            for (int r = 0; r < 4; r++) begin
                if (row_sync_q[r]) bitmap_now[{2'(r), col_idx_q}] = 1'b1;
            end
        end

        // Descending scan leaves the lowest set index, so the lowest code wins.
        raw_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (bitmap_now[i]) raw_code = 4'(i);
        end
        raw_valid = |bitmap_now;

        div_d     = tick ? '0 : div_q + 1'b1;
        col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
        key_col_d = 4'b0001 << col_idx_d;
        bitmap_d  = scan_done ? 16'h0000 : bitmap_now;

        cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_pulse_d = 5'h00;

        if (scan_done) begin
            unique case (state_q)
                IDLE: begin
                    if (raw_valid) begin
                        if (DB_LAST == 4'd1) begin
                            state_d     = HELD;
                            key_d       = {1'b1, raw_code};
                            key_pulse_d = {1'b1, raw_code};
                        end else begin
                            state_d = PRESS_DB;
                            cand_d  = raw_code;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                PRESS_DB: begin
                    if (!raw_valid) begin
                        state_d = IDLE;
                    end else if (raw_code != cand_q) begin
                        cand_d = raw_code;
                        cnt_d  = 4'd1;
                    end else if (cnt_inc == DB_LAST) begin
                        state_d     = HELD;
                        key_d       = {1'b1, cand_q};
                        key_pulse_d = {1'b1, cand_q};
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!raw_valid || raw_code != key_q[3:0]) begin
                        if (DB_LAST == 4'd1) begin
                            state_d = IDLE;
                            key_d   = 5'h00;
                        end else begin
                            state_d = REL_DB;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                REL_DB: begin
                    // key stays valid here so downstream sees no dropout on release bounce.
                    if (raw_valid && raw_code == key_q[3:0]) begin
                        state_d = HELD;
                    end else if (cnt_inc == DB_LAST) begin
                        state_d = IDLE;
                        key_d   = 5'h00;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q  <= 4'h0;
            row_sync_q  <= 4'h0;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            key_col_q   <= 4'b0001;
            bitmap_q    <= 16'h0000;
            state_q     <= IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= 4'h0;
            key_q       <= 5'h00;
            key_pulse_q <= 5'h00;
        end else begin
            row_meta_q  <= key_row;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            key_col_q   <= key_col_d;
            bitmap_q    <= bitmap_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign key_col   = key_col_q;
    assign key       = key_q;
    assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 (scan period 16 clk);
// a behavioural keypad matrix drives key_row from the pressed-key set and key_col.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [4:0]  key;
    logic [4:0]  key_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Row r is high when any pressed key in row r sits on the driven column.
    always_comb begin
        key_row = 4'h0;
        for (int r = 0; r < 4; r++) begin
            key_row[r] = |(pressed[4*r +: 4] & key_col);
        end
    end

    keypad_scan #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key       (key),
        .key_pulse (key_pulse)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scans(input int n);
        step(16 * n);
    endtask

    initial begin
        // 1: reset values, column walk and wrap
        #12;
        check("rst_key_col", key_col, 8'h01);
        check("rst_key", key, 8'h00);
        check("rst_pulse", key_pulse, 8'h00);
        #10 rst = 1'b1;
        #1;
        check("t1_col0", key_col, 8'h01);
        step(3);
        check("t1_col0_hold", key_col, 8'h01);
        step(1);
        check("t1_col1", key_col, 8'h02);
        step(12);
        check("t1_col_wrap", key_col, 8'h01);
        check("t1_key", key, 8'h00);
        check("t1_pulse", key_pulse, 8'h00);

        // 2: steady row0/col1 accepted on the 3rd scan
        pressed = 16'h0002;
        scans(2);
        check("t2_pre_accept", key, 8'h00);
        scans(1);
        check("t2_key", key, 8'h11);
        check("t2_pulse", key_pulse, 8'h11);
        step(1);
        check("t2_pulse_off", key_pulse, 8'h00);
        check("t2_key_hold", key, 8'h11);
        step(15);
        pressed = 16'h0000;
        scans(2);
        check("t2_rel_no_dropout", key, 8'h11);
        scans(1);
        check("t2_released", key, 8'h00);

        // 3: code 5 bouncing every other scan never accepted, then held
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            scans(1);
            check("t3_bounce_key", key, 8'h00);
            check("t3_bounce_pulse", key_pulse, 8'h00);
        end
        pressed = 16'h0020;
        scans(2);
        check("t3_pre_accept", key, 8'h00);
        scans(1);
        check("t3_key", key, 8'h15);
        check("t3_pulse", key_pulse, 8'h15);
        step(1);
        check("t3_pulse_off", key_pulse, 8'h00);
        step(15);

        // 4: adding code 3 forces release debounce then a fresh press debounce
        pressed = 16'h0028;
        scans(1);
        check("t4_rel_db1", key, 8'h15);
        scans(1);
        check("t4_rel_db2", key, 8'h15);
        scans(1);
        check("t4_idle", key, 8'h00);
        check("t4_idle_pulse", key_pulse, 8'h00);
        scans(2);
        check("t4_press_db", key, 8'h00);
        scans(1);
        check("t4_key", key, 8'h13);
        check("t4_pulse", key_pulse, 8'h13);
        step(1);
        check("t4_pulse_off", key_pulse, 8'h00);
        step(15);

        // 5: one-scan release is absorbed; three-scan release clears key
        pressed = 16'h0000;
        scans(1);
        check("t5_rel1_key", key, 8'h13);
        check("t5_rel1_pulse", key_pulse, 8'h00);
        pressed = 16'h0008;
        scans(1);
        check("t5_repress_key", key, 8'h13);
        check("t5_repress_pulse", key_pulse, 8'h00);
        scans(1);
        check("t5_held_pulse", key_pulse, 8'h00);
        pressed = 16'h0000;
        scans(2);
        check("t5_rel_db", key, 8'h13);
        scans(1);
        check("t5_released", key, 8'h00);

        // 6a: reset during press debounce
        pressed = 16'h0002;
        scans(1);
        check("t6_press_db", key, 8'h00);
        step(5);
        check("t6_pre_rst_col", key_col, 8'h02);
        rst = 1'b0;
        #1;
        check("t6_rst_col", key_col, 8'h01);
        check("t6_rst_key", key, 8'h00);
        check("t6_rst_pulse", key_pulse, 8'h00);
        step(2);
        check("t6_rst_col_held", key_col, 8'h01);
        rst = 1'b1;
        scans(2);
        check("t6_fresh_db", key, 8'h00);
        scans(1);
        check("t6_key", key, 8'h11);
        check("t6_pulse", key_pulse, 8'h11);

        // 6b: reset while held
        step(6);
        check("t6_held", key, 8'h11);
        rst = 1'b0;
        #1;
        check("t6h_rst_col", key_col, 8'h01);
        check("t6h_rst_key", key, 8'h00);
        check("t6h_rst_pulse", key_pulse, 8'h00);
        step(2);
        rst = 1'b1;
        scans(2);
        check("t6h_fresh_db", key, 8'h00);
        scans(1);
        check("t6h_key", key, 8'h11);
        check("t6h_pulse", key_pulse, 8'h11);
        step(1);
        check("t6h_pulse_off", key_pulse, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
